arduino_link_rx: RTL and testbench

UART receiver for the Arduino→FPGA direction of the tic-tac-toe board link. It deserialises 8N1 frames from the Arduino and decodes them into the game controller's inputs: `PC` (game mode, held) and `interrupt` (one-cycle cell/restart pulse). It complements the FPGA→Arduino `Arduino[2:0]` path and sits between the board pin and the game FSM.

---
 rtl/arduino_link_rx_if.sv | 17 +
 rtl/arduino_link_rx.sv | 150 +++++++++++++++
 tb/tb_arduino_link_rx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/arduino_link_rx_if.sv
// rtl/arduino_link_rx_if.sv - Arduino-to-FPGA link signal bundle
//   rx        : serial line from the Arduino (idle high)
//   PC        : latched game mode
//   interrupt : one-cycle cell/restart code
//   frame_err : one-cycle error pulse
//   busy      : receiver is mid-frame
// slave is the receiver side, master is the pin/stimulus side.
interface arduino_link_rx_if;
    logic       rx;
    logic [1:0] PC;
    logic [3:0] interrupt;
    logic       frame_err;
    logic       busy;

    modport master (output rx, input PC, interrupt, frame_err, busy);
    modport slave  (input rx, output PC, interrupt, frame_err, busy);
endinterface

// File: rtl/arduino_link_rx.sv
// rtl/arduino_link_rx.sv - 8N1 UART receiver decoding Arduino board frames
//   clk   : system clock
//   Reset : asynchronous, active-high reset
//   link  : arduino_link_rx_if.slave (rx in; PC, interrupt, frame_err, busy out)
module arduino_link_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic               clk,
    input  logic               Reset,
    arduino_link_rx_if.slave   link
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t HALF_CNT = cnt_t'(CLKS_PER_BIT / 2 - 1);
    localparam cnt_t FULL_CNT = cnt_t'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DECODE} state_t;

    state_t     state_q, state_d;
    logic       sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    logic [1:0] arm_q, arm_d;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] pc_q, pc_d;
    logic [3:0] intr_q, intr_d;
    logic       ferr_q, ferr_d;
    logic       start_edge;
    logic       tick;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
            arm_q   <= 2'd0;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            pc_q    <= 2'd0;
            intr_q  <= 4'd0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            arm_q   <= arm_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pc_q    <= pc_d;
            intr_q  <= intr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        sync1_d = link.rx;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        // The synchroniser and history flops hold reset-forced ones for a few
        // cycles after release; edges are ignored until real line samples
        // have reached both, so a line held low across reset is not a start.
        arm_d      = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
        start_edge = (arm_q == 2'd3) && hist_q && !sync2_q;
        tick       = (cnt_q == '0);

        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pc_d    = pc_q;
        intr_d  = 4'd0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = START;
                    cnt_d   = HALF_CNT;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt_q - cnt_t'(1);
                end else if (!sync2_q) begin
                    state_d = DATA;
                    cnt_d   = FULL_CNT;
                    bit_d   = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - cnt_t'(1);
                end else begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = FULL_CNT;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - cnt_t'(1);
                end else if (sync2_q) begin
                    state_d = DECODE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            DECODE: begin
                case (shift_q[7:6])
                    2'b00: begin
                        if (shift_q[5:2] == 4'd0 && shift_q[1:0] != 2'b11) pc_d = shift_q[1:0];
                        else                                             ferr_d = 1'b1;
                    end
                    2'b01: begin
                        if (shift_q[5:4] == 2'd0 && shift_q[3:0] != 4'd0 && shift_q[3:0] <= 4'd9)
                            intr_d = shift_q[3:0];
                        else
                            ferr_d = 1'b1;
                    end
                    2'b10: begin
                        pc_d   = 2'd0;
                        intr_d = 4'hF;
                    end
                    default: ferr_d = 1'b1;
                endcase
                // A back-to-back start edge may land in this cycle.
                if (start_edge) begin
                    state_d = START;
                    cnt_d   = HALF_CNT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign link.PC        = pc_q;
    assign link.interrupt = intr_q;
    assign link.frame_err = ferr_q;
    assign link.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_arduino_link_rx.sv
// tb/tb_arduino_link_rx.sv - self-checking bench for arduino_link_rx
module tb_arduino_link_rx;
    localparam int CPB = 8;
    localparam int LAT = 10 * CPB;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   both_cnt = 0;

    arduino_link_rx_if bus ();

    arduino_link_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .Reset (Reset),
        .link  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] intr;
        logic       ferr;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    always @(negedge clk) begin
        if (!Reset) begin
            if (bus.interrupt != 4'd0 || bus.frame_err)
                obs_q.push_back('{cyc, bus.interrupt, bus.frame_err});
            if (bus.interrupt != 4'd0 && bus.frame_err) both_cnt++;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [1:0] pc;
        logic [3:0] intr;
        logic       ferr;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference decode of one frame from the protocol rules.
    function automatic void ref_frame(input logic [7:0] b, input logic stop, input logic [1:0] pc_in,
                                      output logic [1:0] pc_out, output logic [3:0] intr,
                                      output logic ferr, output int lat);
        int ty, pay;
        ty = int'(b) / 64;
        pay = int'(b) % 64;
        pc_out = pc_in;
        intr = 4'd0;
        ferr = 1'b0;
        lat = LAT;
        if (!stop) begin
            ferr = 1'b1;
            lat = LAT - 1;
        end else if (ty == 0) begin
            if (pay <= 2) pc_out = 2'(pay);
            else ferr = 1'b1;
        end else if (ty == 1) begin
            if (pay >= 1 && pay <= 9) intr = 4'(pay);
            else ferr = 1'b1;
        end else if (ty == 2) begin
            pc_out = 2'd0;
            intr = 4'd15;
        end else begin
            ferr = 1'b1;
        end
    endfunction

    // Called at a negedge; returns at the negedge LAT cycles later.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
        t0 = cyc;
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = stop;
        repeat (CPB) @(negedge clk);
        bus.rx = 1'b1;
    endtask

    task automatic check_events(input string name);
        int n;
        repeat (4) @(negedge clk);
        check({name, " event count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({name, " event cyc*32+intr*2+ferr"},
                  obs_q[i].cyc * 32 + int'(obs_q[i].intr) * 2 + int'(obs_q[i].ferr),
                  exp_q[i].cyc * 32 + int'(exp_q[i].intr) * 2 + int'(exp_q[i].ferr));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[15];
        int         t0;
        logic [7:0] b;
        logic       stop;
        logic [1:0] mpc, npc;
        logic [3:0] mi;
        logic       mf;
        int         lat;

        tbl[0]  = '{8'h02, 1'b1, 2'd2, 4'd0, 1'b0};
        tbl[1]  = '{8'h00, 1'b1, 2'd0, 4'd0, 1'b0};
        tbl[2]  = '{8'h01, 1'b1, 2'd1, 4'd0, 1'b0};
        tbl[3]  = '{8'h45, 1'b1, 2'd1, 4'd5, 1'b0};
        tbl[4]  = '{8'h41, 1'b1, 2'd1, 4'd1, 1'b0};
        tbl[5]  = '{8'h49, 1'b1, 2'd1, 4'd9, 1'b0};
        tbl[6]  = '{8'h4A, 1'b1, 2'd1, 4'd0, 1'b1};
        tbl[7]  = '{8'hC3, 1'b1, 2'd1, 4'd0, 1'b1};
        tbl[8]  = '{8'h45, 1'b0, 2'd1, 4'd0, 1'b1};
        tbl[9]  = '{8'h80, 1'b1, 2'd0, 4'hF, 1'b0};
        tbl[10] = '{8'h03, 1'b1, 2'd0, 4'd0, 1'b1};
        tbl[11] = '{8'h02, 1'b1, 2'd2, 4'd0, 1'b0};
        tbl[12] = '{8'h50, 1'b1, 2'd2, 4'd0, 1'b1};
        tbl[13] = '{8'h40, 1'b1, 2'd2, 4'd0, 1'b1};
        tbl[14] = '{8'hBF, 1'b1, 2'd0, 4'hF, 1'b0};

        bus.rx = 1'b1;
        Reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset PC", bus.PC, 0);
        check("reset interrupt", bus.interrupt, 0);
        check("reset frame_err", bus.frame_err, 0);
        check("reset busy", bus.busy, 0);
        Reset = 1'b0;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            send_frame(tbl[i].data, tbl[i].stop, t0);
            if (tbl[i].intr != 4'd0 || tbl[i].ferr)
                exp_q.push_back('{t0 + (tbl[i].stop ? LAT : LAT - 1), tbl[i].intr, tbl[i].ferr});
            check($sformatf("table[%0d] PC", i), bus.PC, tbl[i].pc);
            check_events($sformatf("table[%0d]", i));
            check($sformatf("table[%0d] busy idle", i), bus.busy, 0);
        end

        // Two-cycle low glitch on an idle line.
        bus.rx = 1'b0;
        repeat (2) @(negedge clk);
        bus.rx = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch busy", bus.busy, 0);
        check("glitch PC", bus.PC, 0);
        check_events("glitch");

        // Back-to-back frames with no idle beyond the stop bit.
        for (int i = 1; i <= 3; i++) begin
            send_frame(8'h40 + 8'(i), 1'b1, t0);
            exp_q.push_back('{t0 + LAT, 4'(i), 1'b0});
        end
        check_events("back-to-back");

        // Reset during data bit 4 of 0x47, line held low through and after reset.
        send_frame(8'h01, 1'b1, t0);
        check("pre-reset PC", bus.PC, 1);
        repeat (4) @(negedge clk);
        b = 8'h47;
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = b[4];
        repeat (CPB / 2) @(negedge clk);
        check("mid-frame busy", bus.busy, 1);
        Reset = 1'b1;
        #1;
        check("async reset PC", bus.PC, 0);
        check("async reset busy", bus.busy, 0);
        check("async reset interrupt", bus.interrupt, 0);
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        repeat (20) @(negedge clk);
        check("low-after-reset busy", bus.busy, 0);
        check_events("after reset");
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h47, 1'b1, t0);
        exp_q.push_back('{t0 + LAT, 4'd7, 1'b0});
        check_events("clean 0x47");

        // Randomised frames against the reference model.
        mpc = bus.PC == 2'd0 ? 2'd0 : 2'd3;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1) == 1) b = 8'(($urandom_range(3) << 6) | $urandom_range(10));
            else                         b = 8'($urandom_range(255));
            stop = ($urandom_range(7) == 0) ? 1'b0 : 1'b1;
            send_frame(b, stop, t0);
            ref_frame(b, stop, mpc, npc, mi, mf, lat);
            mpc = npc;
            if (mi != 4'd0 || mf) exp_q.push_back('{t0 + lat, mi, mf});
            check($sformatf("random[%0d] PC", i), bus.PC, mpc);
            repeat (stop ? $urandom_range(3) : 2 + $urandom_range(3)) @(negedge clk);
        end
        check_events("random");
        check("interrupt/frame_err overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
